// File: rtl/display_sequencer.sv
// display_sequencer
//
// Time-shares a downstream signed-decimal display driver between four processor values
// (operand A, operand B, ALU result, flags). One source is shown per slot, tagged with a
// letter code. Slots advance on a prescaled timer (Auto=1) or on a debounced push-button.
// With Freeze=1 the value captured on slot entry is shown instead of the live source.
//
// Parameters:
//   TICKS_PER_SLOT  clock cycles per slot in auto mode (>= 2)
//   DEB_CYCLES      consecutive differing samples needed to accept a new button level (>= 1)
//
// Ports:
//   clk     system clock, all state on the rising edge
//   rst     synchronous active-high reset
//   ValA    operand A (two's complement)
//   ValB    operand B (two's complement)
//   ValR    ALU result (two's complement)
//   Flags   {N,Z,C,V}
//   Step_n  raw active-low push-button, asynchronous to clk
//   Auto    1 = timer rotation, 0 = manual only
//   Freeze  1 = show the slot-entry snapshot, 0 = live value
//   Num     value to the display driver (registered)
//   Letter  letter code to the display driver (registered)
//   Slot    current slot index

module display_sequencer #(
    parameter int unsigned TICKS_PER_SLOT = 50_000_000,
    parameter int unsigned DEB_CYCLES     = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ValA,
    input  logic [7:0] ValB,
    input  logic [7:0] ValR,
    input  logic [3:0] Flags,
    input  logic       Step_n,
    input  logic       Auto,
    input  logic       Freeze,
    output logic [7:0] Num,
    output logic [3:0] Letter,
    output logic [1:0] Slot
);

    localparam int unsigned PreW = $clog2(TICKS_PER_SLOT);
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_SLOT - 1);
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {
        StShow,
        StLoad
    } state_e;

    state_e          state_q;
    logic [1:0]      slot_q;
    logic [7:0]      snap_q;
    logic [7:0]      num_q;
    logic [3:0]      letter_q;

    logic            sync1_q;
    logic            sync2_q;
    logic [DebW-1:0] deb_cnt_q;
    logic            acc_q;
    logic            acc_prev_q;
    logic            press_q;

    logic [PreW-1:0] presc_q;
    logic            auto_q;

    logic            tick;
    logic            advance;
    logic [7:0]      live_val;
    logic [3:0]      live_code;

    // Source and letter code for the current slot.
    always_comb begin
        live_val  = ValA;
        live_code = 4'hA;
        unique case (slot_q)
            2'd0: begin
                live_val  = ValA;
                live_code = 4'hA;
            end
            2'd1: begin
                live_val  = ValB;
                live_code = 4'hB;
            end
            2'd2: begin
                live_val  = ValR;
                live_code = 4'hC;
            end
            2'd3: begin
                live_val  = {4'b0000, Flags};
                live_code = 4'hE;
            end
            default: begin
                live_val  = ValA;
                live_code = 4'hA;
            end
        endcase
    end

    // Button path: two-flop synchronizer, debounce, falling-edge detect on the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_cnt_q  <= '0;
            acc_q      <= 1'b1;
            acc_prev_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= Step_n;
            sync2_q    <= sync1_q;
            acc_prev_q <= acc_q;
            press_q    <= acc_prev_q & ~acc_q;
            if (sync2_q == acc_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DebLast) begin
                acc_q     <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    assign tick    = (presc_q == PreLast);
    assign advance = (state_q == StShow) && (press_q || (tick && Auto));

    // Prescaler. Held at zero through the LOAD cycle so a full auto slot spans
    // TICKS_PER_SLOT SHOW cycles plus the LOAD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            auto_q  <= Auto;
        end else begin
            auto_q <= Auto;
            if (!Auto || (Auto != auto_q) || advance || (state_q == StLoad) || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    // Slot FSM with registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StShow;
            slot_q   <= 2'd0;
            snap_q   <= 8'h00;
            num_q    <= 8'h00;
            letter_q <= 4'hA;
        end else begin
            letter_q <= live_code;
            // During LOAD the snapshot is being captured from the live source, so showing the
            // live value keeps Num consistent with the snapshot from the first cycle of the slot.
            num_q    <= (Freeze && (state_q == StShow)) ? snap_q : live_val;
            unique case (state_q)
                StShow: begin
                    if (advance) begin
                        slot_q  <= slot_q + 2'd1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    snap_q  <= live_val;
                    state_q <= StShow;
                end
                default: state_q <= StShow;
            endcase
        end
    end

    assign Num    = num_q;
    assign Letter = letter_q;
    assign Slot   = slot_q;

endmodule
